// File: rtl/gb_apu_pulse_ctrl.sv
// Register bank and frame-sequencer controller for one APU pulse channel.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   apu_on              - APU power (NR52 bit 7); low clears the bank and sequencer
//   div_tick            - one-cycle 512 Hz frame-sequencer event
//   wr_en, rd_en, addr, wdata, rdata - register port; addr 0..4 = NR10..NR14
//   enable              - channel-active status from the pulse channel
//   ch_active, dac_en   - status derived from NR12 and enable
//   clk_length_ctr, clk_sweep, clk_vol_env - frame-sequencer strobes
//   sweep_*/wave_duty/length/initial_volume/envelope_*/frequency/single - fields
//   length_load, start  - one-cycle strobes on NR11 write / NR14 trigger
module gb_apu_pulse_ctrl #(
  parameter bit HAS_SWEEP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        apu_on,
  input  logic        div_tick,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [2:0]  addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  input  logic        enable,
  output logic        ch_active,
  output logic        dac_en,
  output logic        clk_length_ctr,
  output logic        clk_sweep,
  output logic        clk_vol_env,
  output logic [2:0]  sweep_time,
  output logic        sweep_decreasing,
  output logic [2:0]  num_sweep_shifts,
  output logic [1:0]  wave_duty,
  output logic [5:0]  length,
  output logic        length_load,
  output logic [3:0]  initial_volume,
  output logic        envelope_increasing,
  output logic [2:0]  num_envelope_sweeps,
  output logic [10:0] frequency,
  output logic        single,
  output logic        start
);

  localparam int unsigned STEP_W = 3;
  localparam int unsigned FREQ_W = 11;

  localparam logic [2:0] ADDR_NR10 = 3'd0;
  localparam logic [2:0] ADDR_NR11 = 3'd1;
  localparam logic [2:0] ADDR_NR12 = 3'd2;
  localparam logic [2:0] ADDR_NR13 = 3'd3;
  localparam logic [2:0] ADDR_NR14 = 3'd4;

  logic [6:0]        nr10_q, nr10_d;
  logic [1:0]        duty_q, duty_d;
  logic [5:0]        length_q, length_d;
  logic [7:0]        nr12_q, nr12_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              single_q, single_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              len_stb_q, len_stb_d;
  logic              sweep_stb_q, sweep_stb_d;
  logic              env_stb_q, env_stb_d;
  logic              start_q, start_d;
  logic              length_load_q, length_load_d;
  logic [7:0]        rdata_q, rdata_d;

  // Next-state: read mux, register writes, frame sequencer.
  always_comb begin
    nr10_d        = nr10_q;
    duty_d        = duty_q;
    length_d      = length_q;
    nr12_d        = nr12_q;
    freq_d        = freq_q;
    single_d      = single_q;
    step_d        = step_q;
    rdata_d       = rdata_q;
    len_stb_d     = 1'b0;
    sweep_stb_d   = 1'b0;
    env_stb_d     = 1'b0;
    start_d       = 1'b0;
    length_load_d = 1'b0;

    // Read uses current register state, so a same-cycle write is not visible.
    if (rd_en) begin
      case (addr)
        ADDR_NR10: rdata_d = HAS_SWEEP ? {1'b1, nr10_q} : 8'hFF;
        ADDR_NR11: rdata_d = {duty_q, 6'h3F};
        ADDR_NR12: rdata_d = nr12_q;
        ADDR_NR14: rdata_d = {1'b1, single_q, 6'h3F};
        default:   rdata_d = 8'hFF;
      endcase
    end

    if (!apu_on) begin
      nr10_d   = '0;
      duty_d   = '0;
      length_d = '0;
      nr12_d   = '0;
      freq_d   = '0;
      single_d = 1'b0;
      step_d   = '0;
    end else begin
      if (wr_en) begin
        case (addr)
          ADDR_NR10: if (HAS_SWEEP) nr10_d = wdata[6:0];
          ADDR_NR11: begin
            duty_d        = wdata[7:6];
            length_d      = wdata[5:0];
            length_load_d = 1'b1;
          end
          ADDR_NR12: nr12_d = wdata;
          ADDR_NR13: freq_d[7:0] = wdata;
          ADDR_NR14: begin
            freq_d[10:8] = wdata[2:0];
            single_d     = wdata[6];
            start_d      = wdata[7];
          end
          default: ;
        endcase
      end

      // Length on even steps, sweep on 2 and 6, envelope on 7.
      if (div_tick) begin
        len_stb_d   = ~step_q[0];
        sweep_stb_d = HAS_SWEEP && (step_q[1:0] == 2'd2);
        env_stb_d   = (step_q == 3'd7);
        step_d      = step_q + STEP_W'(1);
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      nr10_q        <= '0;
      duty_q        <= '0;
      length_q      <= '0;
      nr12_q        <= '0;
      freq_q        <= '0;
      single_q      <= 1'b0;
      step_q        <= '0;
      rdata_q       <= '0;
      len_stb_q     <= 1'b0;
      sweep_stb_q   <= 1'b0;
      env_stb_q     <= 1'b0;
      start_q       <= 1'b0;
      length_load_q <= 1'b0;
    end else begin
      nr10_q        <= nr10_d;
      duty_q        <= duty_d;
      length_q      <= length_d;
      nr12_q        <= nr12_d;
      freq_q        <= freq_d;
      single_q      <= single_d;
      step_q        <= step_d;
      rdata_q       <= rdata_d;
      len_stb_q     <= len_stb_d;
      sweep_stb_q   <= sweep_stb_d;
      env_stb_q     <= env_stb_d;
      start_q       <= start_d;
      length_load_q <= length_load_d;
    end
  end

  assign rdata               = rdata_q;
  assign dac_en              = (nr12_q[7:3] != 5'd0);
  assign ch_active           = enable & dac_en;
  assign clk_length_ctr      = len_stb_q;
  assign clk_sweep           = sweep_stb_q;
  assign clk_vol_env         = env_stb_q;
  assign sweep_time          = nr10_q[6:4];
  assign sweep_decreasing    = nr10_q[3];
  assign num_sweep_shifts    = nr10_q[2:0];
  assign wave_duty           = duty_q;
  assign length              = length_q;
  assign length_load         = length_load_q;
  assign initial_volume      = nr12_q[7:4];
  assign envelope_increasing = nr12_q[3];
  assign num_envelope_sweeps = nr12_q[2:0];
  assign frequency           = freq_q;
  assign single              = single_q;
  assign start               = start_q;

endmodule

// File: tb/tb_gb_apu_pulse_ctrl.sv
// Self-checking bench: a channel-1 and a channel-2 instance share stimulus.
// A strobe model and a read-data queue are compared every negedge.
module tb_gb_apu_pulse_ctrl;

  logic clk = 1'b0;
  logic reset, apu_on, div_tick, wr_en, rd_en, enable;
  logic [2:0] addr;
  logic [7:0] wdata;

  logic [7:0]  rdata1, rdata2;
  logic        cha1, cha2, dac1, dac2, len1, len2, swp1, swp2, env1, env2;
  logic [2:0]  st1, st2, ns1, ns2, nes1, nes2;
  logic        sd1, sd2, ll1, ll2, ei1, ei2, sgl1, sgl2, stt1, stt2;
  logic [1:0]  du1, du2;
  logic [5:0]  lg1, lg2;
  logic [3:0]  iv1, iv2;
  logic [10:0] fr1, fr2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gb_apu_pulse_ctrl #(.HAS_SWEEP(1'b1)) dut1 (
    .clk(clk), .reset(reset), .apu_on(apu_on), .div_tick(div_tick),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata), .rdata(rdata1),
    .enable(enable), .ch_active(cha1), .dac_en(dac1),
    .clk_length_ctr(len1), .clk_sweep(swp1), .clk_vol_env(env1),
    .sweep_time(st1), .sweep_decreasing(sd1), .num_sweep_shifts(ns1),
    .wave_duty(du1), .length(lg1), .length_load(ll1),
    .initial_volume(iv1), .envelope_increasing(ei1), .num_envelope_sweeps(nes1),
    .frequency(fr1), .single(sgl1), .start(stt1));

  gb_apu_pulse_ctrl #(.HAS_SWEEP(1'b0)) dut2 (
    .clk(clk), .reset(reset), .apu_on(apu_on), .div_tick(div_tick),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata), .rdata(rdata2),
    .enable(enable), .ch_active(cha2), .dac_en(dac2),
    .clk_length_ctr(len2), .clk_sweep(swp2), .clk_vol_env(env2),
    .sweep_time(st2), .sweep_decreasing(sd2), .num_sweep_shifts(ns2),
    .wave_duty(du2), .length(lg2), .length_load(ll2),
    .initial_volume(iv2), .envelope_increasing(ei2), .num_envelope_sweeps(nes2),
    .frequency(fr2), .single(sgl2), .start(stt2));

  // Packed field views: {sweep_time, dec, shifts, duty, length, vol, inc, sweeps, freq, single}
  logic [34:0] f1, f2;
  assign f1 = {st1, sd1, ns1, du1, lg1, iv1, ei1, nes1, fr1, sgl1};
  assign f2 = {st2, sd2, ns2, du2, lg2, iv2, ei2, nes2, fr2, sgl2};

  logic [4:0] s1, s2;  // {length, sweep, envelope, start, length_load}
  assign s1 = {len1, swp1, env1, stt1, ll1};
  assign s2 = {len2, swp2, env2, stt2, ll2};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Strobe model: expected strobes for the next cycle, pushed at each edge.
  logic [9:0] exp_q[$];
  logic [15:0] rd_q[$];
  bit rd_due = 1'b0;
  int m_step = 0;

  always @(posedge clk) begin
    logic [4:0] e;
    e = '0;
    rd_due = rd_en && !reset;
    if (reset || !apu_on) begin
      m_step = 0;
    end else begin
      if (div_tick) begin
        e[4] = (m_step % 2 == 0);
        e[3] = (m_step == 2 || m_step == 6);
        e[2] = (m_step == 7);
        m_step = (m_step + 1) % 8;
      end
      if (wr_en && addr == 3'd1) e[0] = 1'b1;
      if (wr_en && addr == 3'd4 && wdata[7]) e[1] = 1'b1;
    end
    exp_q.push_back({e, e & 5'b10111});
  end

  int len_cnt = 0, swp_cnt = 0, env_cnt = 0;

  always @(negedge clk) begin
    logic [9:0] e;
    logic [15:0] r;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("strobes_ch1", 64'(s1), 64'(e[9:5]));
      chk("strobes_ch2", 64'(s2), 64'(e[4:0]));
    end
    if (rd_due) begin
      if (rd_q.size() > 0) begin
        r = rd_q.pop_front();
        chk("rdata_ch1", 64'(rdata1), 64'(r[15:8]));
        chk("rdata_ch2", 64'(rdata2), 64'(r[7:0]));
      end else begin
        chk("rd_queue_underflow", 64'(1), 64'(0));
      end
    end
    if (len1) len_cnt++;
    if (swp1) swp_cnt++;
    if (env1) env_cnt++;
  end

  typedef struct {
    bit         wr;
    bit         rd;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] exp1;
    logic [7:0] exp2;
  } vec_t;

  vec_t tbl[17];

  task automatic apply_vec(input vec_t v);
    wr_en = v.wr; rd_en = v.rd; addr = v.a; wdata = v.d;
    if (v.rd) rd_q.push_back({v.exp1, v.exp2});
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic tick();
    div_tick = 1'b1;
    @(negedge clk);
    div_tick = 1'b0;
  endtask

  initial begin
    int l0, s0, e0;
    reset = 1'b1; apu_on = 1'b0; div_tick = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    enable = 1'b0; addr = '0; wdata = '0;

    tbl[0]  = '{1'b1, 1'b0, 3'd0, 8'h7F, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 3'd1, 8'h81, 8'h00, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 3'd2, 8'h1F, 8'h00, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 3'd3, 8'hFF, 8'h00, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 3'd4, 8'hC7, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 3'd0, 8'h00, 8'hFF, 8'hFF};
    tbl[6]  = '{1'b0, 1'b1, 3'd1, 8'h00, 8'hBF, 8'hBF};
    tbl[7]  = '{1'b0, 1'b1, 3'd2, 8'h00, 8'h1F, 8'h1F};
    tbl[8]  = '{1'b0, 1'b1, 3'd3, 8'h00, 8'hFF, 8'hFF};
    tbl[9]  = '{1'b0, 1'b1, 3'd4, 8'h00, 8'hFF, 8'hFF};
    tbl[10] = '{1'b0, 1'b1, 3'd6, 8'h00, 8'hFF, 8'hFF};
    tbl[11] = '{1'b0, 1'b1, 3'd5, 8'h00, 8'hFF, 8'hFF};
    tbl[12] = '{1'b1, 1'b1, 3'd2, 8'h55, 8'h1F, 8'h1F};
    tbl[13] = '{1'b0, 1'b1, 3'd2, 8'h00, 8'h55, 8'h55};
    tbl[14] = '{1'b1, 1'b0, 3'd4, 8'h00, 8'h00, 8'h00};
    tbl[15] = '{1'b0, 1'b1, 3'd4, 8'h00, 8'hBF, 8'hBF};
    tbl[16] = '{1'b1, 1'b1, 3'd0, 8'h3A, 8'hFF, 8'hFF};

    repeat (3) @(negedge clk);
    chk("reset_fields", 64'(f1), 64'(0));
    chk("reset_outs", 64'({rdata1, dac1, cha1, s1}), 64'(0));
    reset = 1'b0; apu_on = 1'b1;

    // 16 ticks spaced 64 clocks: 8 length, 4 sweep, 2 envelope strobes.
    l0 = len_cnt; s0 = swp_cnt; e0 = env_cnt;
    for (int i = 0; i < 16; i++) begin
      tick();
      repeat (63) @(negedge clk);
    end
    chk("len_count", 64'(len_cnt - l0), 64'(8));
    chk("sweep_count", 64'(swp_cnt - s0), 64'(4));
    chk("env_count", 64'(env_cnt - e0), 64'(2));

    // Register writes, then field values.
    for (int i = 0; i < 5; i++) apply_vec(tbl[i]);
    chk("start_after_nr14", 64'(stt1), 64'(1));
    chk("fields_ch1", 64'(f1),
        64'({3'd7, 1'b1, 3'd7, 2'd2, 6'd1, 4'd1, 1'b1, 3'd7, 11'h7FF, 1'b1}));
    chk("fields_ch2", 64'(f2),
        64'({3'd0, 1'b0, 3'd0, 2'd2, 6'd1, 4'd1, 1'b1, 3'd7, 11'h7FF, 1'b1}));
    @(negedge clk);
    chk("start_one_cycle", 64'(stt1), 64'(0));

    // Readback, same-cycle rd/wr, NR14 clear.
    for (int i = 5; i < 17; i++) apply_vec(tbl[i]);
    chk("freq_after_nr14_clear", 64'({fr1, sgl1}), 64'({11'h0FF, 1'b0}));
    chk("nr10_ch1_after_3a", 64'({st1, sd1, ns1}), 64'(7'h3A));
    chk("nr10_ch2_ignored", 64'({st2, sd2, ns2}), 64'(0));

    // DAC enable from NR12[7:3].
    enable = 1'b1;
    wr(3'd2, 8'h07);
    chk("dac_07", 64'({dac1, cha1, dac2, cha2}), 64'(0));
    wr(3'd2, 8'h08);
    chk("dac_08", 64'({dac1, cha1, dac2, cha2}), 64'(4'hF));
    enable = 1'b0; #1;
    chk("ch_active_enable_low", 64'({dac1, cha1}), 64'(2'b10));
    enable = 1'b1;

    // Trigger write coincident with the step-2 tick.
    tick(); tick();
    div_tick = 1'b1; wr_en = 1'b1; addr = 3'd4; wdata = 8'h80;
    @(negedge clk);
    div_tick = 1'b0; wr_en = 1'b0;
    chk("coincident_strobes", 64'({len1, swp1, env1, stt1}), 64'(4'b1101));
    @(negedge clk);
    chk("coincident_cleared", 64'({len1, swp1, env1, stt1}), 64'(0));

    // Reset during a length strobe (step 4), then restart at step 0.
    tick();
    tick();
    chk("len_step4", 64'(len1), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("len_after_reset", 64'(len1), 64'(0));
    reset = 1'b0;
    chk("fields_after_reset", 64'(f1), 64'(0));
    tick();
    chk("restart_step0", 64'({len1, swp1, env1}), 64'(3'b100));

    // Power off at step 5: bank cleared, writes and ticks ignored.
    wr(3'd1, 8'h81);
    chk("nr11_before_off", 64'({du1, lg1}), 64'({2'd2, 6'd1}));
    repeat (4) tick();
    apu_on = 1'b0;
    @(negedge clk);
    chk("fields_off", 64'(f1), 64'(0));
    wr(3'd1, 8'hFF);
    chk("nr11_write_off", 64'({f1, ll1}), 64'(0));
    wr(3'd4, 8'h80);
    chk("trigger_off", 64'(stt1), 64'(0));
    tick();
    chk("tick_off", 64'(s1), 64'(0));
    apu_on = 1'b1;
    @(negedge clk);
    tick();
    chk("power_on_step0", 64'({len1, swp1, env1}), 64'(3'b100));
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gb_apu_pulse_ctrl.md
Name: gb_apu_pulse_ctrl

Overview:
Register-interface and sequencing controller for one APU pulse channel. It holds the NR10–NR14 register bank and drives the channel's configuration fields. It issues the single-cycle trigger (start) strobe on NR14 writes. It runs the 8-step frame sequencer that produces the length, sweep and envelope clock strobes from the 512 Hz DIV-APU event.

Parameters:
HAS_SWEEP, 1, 1 = channel 1 (NR10 sweep implemented); 0 = channel 2 (NR10 absent, sweep outputs tied 0)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
apu_on  in  1  NR52 bit7; low = APU powered off
div_tick  in  1  one-cycle 512 Hz frame-sequencer event
wr_en  in  1  register write strobe
rd_en  in  1  register read strobe
addr  in  3  0..4 = NR10..NR14; 5..7 unmapped
wdata  in  8  write data
rdata  out  8  registered read data
enable  in  1  channel-active status from pulse channel
ch_active  out  1  enable & dac_en (feeds NR52 status)
dac_en  out  1  NR12[7:3] != 0
clk_length_ctr  out  1  length-counter strobe
clk_sweep  out  1  sweep strobe
clk_vol_env  out  1  envelope strobe
sweep_time  out  3  NR10[6:4]
sweep_decreasing  out  1  NR10[3]
num_sweep_shifts  out  3  NR10[2:0]
wave_duty  out  2  NR11[7:6]
length  out  6  NR11[5:0]
length_load  out  1  one-cycle strobe on NR11 write
initial_volume  out  4  NR12[7:4]
envelope_increasing  out  1  NR12[3]
num_envelope_sweeps  out  3  NR12[2:0]
frequency  out  11  {NR14[2:0], NR13}
single  out  1  NR14[6] length enable
start  out  1  one-cycle trigger strobe

Behaviour:
- Reset (sync, priority over all): all register fields 0, step counter 0, every output 0 (rdata 0x00, dac_en 0, all strobes 0).
- Writes (wr_en=1, apu_on=1) update fields at the clock edge; outputs reflect the new value the next cycle. Writes with apu_on=0 are ignored.
- NR13 updates only frequency[7:0]. NR14 updates frequency[10:8] and single. Bits 5:3 are discarded.
- NR11 write: length_load=1 for exactly the following cycle.
- NR14 write with wdata[7]=1: start=1 for exactly the following cycle. Trigger bit is not stored. Back-to-back trigger writes give back-to-back start pulses.
- HAS_SWEEP=0: NR10 writes ignored; sweep fields and clk_sweep held 0.
- Reads: rd_en=1 loads rdata at the edge (1-cycle latency); rdata holds its value otherwise. Write-only bits read as 1:
  - NR10: {1, NR10[6:0]}; 0xFF if HAS_SWEEP=0.
  - NR11: {duty, 6'b111111}.
  - NR12: full byte.
  - NR13: 0xFF.
  - NR14: {1, single, 6'b111111}.
  - addr 5..7: 0xFF.
  - Simultaneous rd/wr to the same address returns the old value.
- Frame sequencer: 3-bit step counter; on div_tick with apu_on=1, the strobes for the current step assert the next cycle for exactly 1 cycle, and the step increments mod 8.
  - Step 0, 2, 4, 6: clk_length_ctr.
  - Step 2, 6: clk_sweep.
  - Step 7: clk_vol_env.
  - Steps 1, 3, 5: no strobe.
- apu_on low: step counter forced to 0, all register fields cleared to 0, no strobes; start/length_load suppressed.
- On apu_on rising, the first div_tick is step 0.
- Simultaneous div_tick and trigger write: both strobes issue in the same cycle; neither is dropped.
- dac_en and ch_active are combinational from registered state (NR12 and enable input).
- reset asserted mid-pulse: the strobe deasserts the next cycle and the sequencer restarts at step 0.

Test Plan:
- Reset, apu_on=1, 16 div_ticks spaced 64 clk -> clk_length_ctr on ticks 1,3,5,7,9,11,13,15 (steps 0,2,4,6); clk_sweep on steps 2,6; clk_vol_env on step 7 only; each strobe exactly 1 cycle, 1 cycle after div_tick.
- Write NR10=0x7F, NR11=0x81, NR12=0x1F, NR13=0xFF, NR14=0xC7 -> sweep_time=7, sweep_decreasing=1, num_sweep_shifts=7, wave_duty=2, length=1, length_load pulse, initial_volume=1, envelope_increasing=1, num_envelope_sweeps=7, frequency=0x7FF, single=1, start pulse 1 cycle after NR14 write.
- Readback after above -> NR10=0xFF, NR11=0xBF, NR12=0x1F, NR13=0xFF, NR14=0xFF; addr 6 -> 0xFF; NR14=0x00 then read -> 0xBF.
- NR12=0x07 with enable=1 -> dac_en=0, ch_active=0; NR12=0x08 -> dac_en=1, ch_active=1.
- NR14=0x80 write in the same cycle as div_tick at step 2 -> start, clk_length_ctr, clk_sweep all high in the same single cycle.
- apu_on=0 mid-sequence (step 5) then write NR11=0xFF -> fields stay 0, no strobes; apu_on=1 + div_tick -> clk_length_ctr (step 0). HAS_SWEEP=0 instance: NR10 write 0x7F -> sweep fields 0, read 0xFF, clk_sweep never asserts.
